// File: rtl/spi_link_pkg.sv
// Shared command codes, state encoding, tx source selects and status bit
// positions for the SPI link router.
package spi_link_pkg;

    localparam logic [7:0] CMD_REG     = 8'h89;
    localparam logic [7:0] CMD_FIFO_RD = 8'h8A;
    localparam logic [7:0] CMD_FIFO_WR = 8'h8B;
    localparam logic [7:0] CMD_STATUS  = 8'h8C;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_REG_ADDR  = 3'd1;
    localparam state_t S_REG_DATA  = 3'd2;
    localparam state_t S_REG_DUMMY = 3'd3;
    localparam state_t S_CH        = 3'd4;
    localparam state_t S_LEN       = 3'd5;
    localparam state_t S_RD_DATA   = 3'd6;
    localparam state_t S_WR_DATA   = 3'd7;

    typedef logic [1:0] src_t;
    localparam src_t SRC_REG    = 2'd0;
    localparam src_t SRC_FIFO   = 2'd1;
    localparam src_t SRC_FILL   = 2'd2;
    localparam src_t SRC_STATUS = 2'd3;

    localparam int STAT_UNF    = 0;
    localparam int STAT_OVF    = 1;
    localparam int STAT_BAD_CH = 2;

endpackage

// File: rtl/spi_link_rd_pipe.sv
// Delays a read request by RD_LAT cycles so the tx load lands exactly when
// the addressed register or FIFO presents its data.
module spi_link_rd_pipe
    import spi_link_pkg::*;
#(
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  src_t        src,
    input  logic [7:0]  reg_rdata,
    input  logic [7:0]  fifo_byte,
    input  logic [7:0]  status_byte,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        status_load
);

    logic       vld   [RD_LAT];
    src_t       src_q [RD_LAT];
    logic [7:0] held;
    logic [7:0] sel_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld[k]   <= 1'b0;
                src_q[k] <= SRC_FILL;
            end
        end else begin
            vld[0]   <= req;
            src_q[0] <= src;
            for (int k = 1; k < RD_LAT; k++) begin
                vld[k]   <= vld[k-1];
                src_q[k] <= src_q[k-1];
            end
        end
    end

    always_comb begin
        sel_byte = FILL_BYTE;
        case (src_q[RD_LAT-1])
            SRC_REG:    sel_byte = reg_rdata;
            SRC_FIFO:   sel_byte = fifo_byte;
            SRC_STATUS: sel_byte = status_byte;
            default:    sel_byte = FILL_BYTE;
        endcase
    end

    // The data source is only valid in the strobe cycle, so keep the last
    // loaded byte steady on the output between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            held <= 8'h00;
        else if (tx_valid)
            held <= sel_byte;
    end

    assign tx_valid    = vld[RD_LAT-1];
    assign tx_data     = tx_valid ? sel_byte : held;
    assign status_load = tx_valid && (src_q[RD_LAT-1] == SRC_STATUS);

endmodule

// File: rtl/spi_link_router.sv
// Byte-level command decoder steering SPI frames to a register space or to
// one of N_CH FIFO channels, with sticky error flags readable via STATUS.
module spi_link_router
    import spi_link_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter int          ADDR_W    = 7,
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          spi_data,
    input  logic                valid,
    input  logic                spi_cs_n,
    output logic [7:0]          spi_data_out,
    output logic                spi_tx_valid,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic                reg_we,
    output logic [7:0]          reg_wdata,
    input  logic [7:0]          reg_rdata,
    output logic [N_CH-1:0]     fifo_rd,
    input  logic [8*N_CH-1:0]   fifo_rdata,
    input  logic [N_CH-1:0]     fifo_empty,
    output logic [N_CH-1:0]     fifo_we,
    output logic [7:0]          fifo_wdata,
    input  logic [N_CH-1:0]     fifo_full,
    output logic                busy
);

    state_t      state;
    logic [3:0]  ch;
    logic        dir_wr;
    logic        reg_rw;
    logic [8:0]  count;
    logic [2:0]  flags;
    logic [2:0]  flag_set;
    logic        rd_req;
    src_t        rd_src;
    logic        act;
    logic        ch_ok;
    logic        sel_empty;
    logic        sel_full;
    logic [7:0]  sel_rdata;
    logic [N_CH-1:0] ch_onehot;
    logic        fifo_rd_issue;
    logic        status_load;
    logic [7:0]  status_byte;

    assign act   = valid && !spi_cs_n;
    assign ch_ok = {1'b0, ch} < 5'(N_CH);
    assign busy  = (state != S_IDLE);

    // An out-of-range channel looks empty and full so it can never strobe.
    always_comb begin
        ch_onehot = '0;
        sel_empty = 1'b1;
        sel_full  = 1'b1;
        sel_rdata = FILL_BYTE;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == 4'(c)) begin
                ch_onehot[c] = 1'b1;
                sel_empty    = fifo_empty[c];
                sel_full     = fifo_full[c];
                sel_rdata    = fifo_rdata[8*c +: 8];
            end
        end
    end

    always_comb begin
        fifo_rd_issue = act && (((state == S_LEN) && !dir_wr) ||
                                ((state == S_RD_DATA) && (count > 9'd1)));
        flag_set              = 3'b000;
        flag_set[STAT_UNF]    = fifo_rd_issue && ch_ok && sel_empty;
        flag_set[STAT_OVF]    = act && (state == S_WR_DATA) && ch_ok && sel_full;
        flag_set[STAT_BAD_CH] = act && (state == S_CH) &&
                                ({1'b0, spi_data[3:0]} >= 5'(N_CH));
        status_byte = {5'b00000, flags[STAT_BAD_CH], flags[STAT_OVF], flags[STAT_UNF]};
    end

    // A flag raised in the same cycle the status byte is loaded survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags <= 3'b000;
        else
            flags <= (flags & ~{3{status_load}}) | flag_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= 4'h0;
            dir_wr     <= 1'b0;
            reg_rw     <= 1'b0;
            count      <= 9'd0;
            reg_addr   <= '0;
            reg_we     <= 1'b0;
            reg_wdata  <= 8'h00;
            fifo_rd    <= '0;
            fifo_we    <= '0;
            fifo_wdata <= 8'h00;
            rd_req     <= 1'b0;
            rd_src     <= SRC_FILL;
        end else begin
            reg_we  <= 1'b0;
            fifo_rd <= '0;
            fifo_we <= '0;
            rd_req  <= 1'b0;
            if (spi_cs_n) begin
                state <= S_IDLE;
            end else if (valid) begin
                case (state)
                    S_IDLE: begin
                        if (spi_data == CMD_REG) begin
                            state <= S_REG_ADDR;
                        end else if ((spi_data == CMD_FIFO_RD) || (spi_data == CMD_FIFO_WR)) begin
                            dir_wr <= (spi_data == CMD_FIFO_WR);
                            state  <= S_CH;
                        end else if (spi_data == CMD_STATUS) begin
                            rd_req <= 1'b1;
                            rd_src <= SRC_STATUS;
                        end
                    end
                    S_REG_ADDR: begin
                        reg_rw   <= spi_data[7];
                        reg_addr <= spi_data[ADDR_W-1:0];
                        if (!spi_data[7]) begin
                            rd_req <= 1'b1;
                            rd_src <= SRC_REG;
                        end
                        state <= S_REG_DATA;
                    end
                    S_REG_DATA: begin
                        if (reg_rw) begin
                            reg_wdata <= spi_data;
                            reg_we    <= 1'b1;
                        end
                        state <= S_REG_DUMMY;
                    end
                    S_REG_DUMMY: state <= S_IDLE;
                    S_CH: begin
                        ch    <= spi_data[3:0];
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        count <= (spi_data == 8'h00) ? 9'd256 : {1'b0, spi_data};
                        state <= dir_wr ? S_WR_DATA : S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        if (count != 9'd0)
                            count <= count - 9'd1;
                        if (count <= 9'd1)
                            state <= S_IDLE;
                    end
                    S_WR_DATA: begin
                        if (ch_ok && !sel_full) begin
                            fifo_wdata <= spi_data;
                            fifo_we    <= ch_onehot;
                        end
                        if (count != 9'd0)
                            count <= count - 9'd1;
                        if (count <= 9'd1)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
            if (fifo_rd_issue) begin
                rd_req <= 1'b1;
                if (ch_ok && !sel_empty) begin
                    fifo_rd <= ch_onehot;
                    rd_src  <= SRC_FIFO;
                end else begin
                    rd_src  <= SRC_FILL;
                end
            end
        end
    end

    spi_link_rd_pipe #(
        .RD_LAT    (RD_LAT),
        .FILL_BYTE (FILL_BYTE)
    ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .req         (rd_req),
        .src         (rd_src),
        .reg_rdata   (reg_rdata),
        .fifo_byte   (sel_rdata),
        .status_byte (status_byte),
        .tx_valid    (spi_tx_valid),
        .tx_data     (spi_data_out),
        .status_load (status_load)
    );

endmodule

// File: doc/spi_link_router.md
Name: spi_link_router

Overview:
- Byte-level command decoder between the SPI slave and N_CH data channels plus one register space; successor to the single-channel SPI link state machine.
- Adds per-channel FIFO selection, burst FIFO transfers with a length byte, empty/full protection with sticky error flags, a status command, and frame abort on chip-select.
- Sits between SPI_Slave (rx byte/valid in, tx byte/valid out) and sdc_controller-style register and FIFO ports.

Parameters:
- N_CH, 2, number of FIFO channels (1..16).
- ADDR_W, 7, register address width.
- RD_LAT, 1, cycles from reg_addr/fifo_rd to valid read data (1..3).
- FILL_BYTE, 8'h00, byte transmitted when no data is available.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- spi_data  in  8  received SPI byte
- valid  in  1  one-cycle strobe, spi_data is valid
- spi_cs_n  in  1  chip select; high aborts the frame
- spi_data_out  out  8  next byte to transmit
- spi_tx_valid  out  1  one-cycle load strobe for spi_data_out
- reg_addr  out  ADDR_W  register address
- reg_we  out  1  register write strobe
- reg_wdata  out  8  register write data
- reg_rdata  in  8  register read data
- fifo_rd  out  N_CH  per-channel read strobe
- fifo_rdata  in  8*N_CH  per-channel read data, channel c at [8c+7:8c]
- fifo_empty  in  N_CH  per-channel empty flag
- fifo_we  out  N_CH  per-channel write strobe
- fifo_wdata  out  8  shared write data
- fifo_full  in  N_CH  per-channel full flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; sticky flags cleared; remaining-byte counter 0.
- All actions occur on cycles where valid=1 unless stated otherwise. spi_cs_n=1 forces IDLE on the next edge from any state; no strobe is issued that cycle; flags are kept.
- States: IDLE, REG_ADDR, REG_DATA, REG_DUMMY, CH, LEN, RD_DATA, WR_DATA.
- IDLE decodes the command byte:
  - 0x89 goes to REG_ADDR.
  - 0x8A and 0x8B go to CH, with the direction latched.
  - 0x8C is STATUS: stays in IDLE, and RD_LAT cycles later loads {5'b0, bad_ch, ovf, unf} as tx and then clears the flags. A flag-setting event in the clear cycle wins.
  - Any other byte is ignored.
- REG_ADDR: latch rw=byte[7] and addr=byte[ADDR_W-1:0]; reg_addr updates on the next cycle. For a read, reg_rdata is sampled RD_LAT cycles after reg_addr updates, driven on spi_data_out, and spi_tx_valid is pulsed. Next state is REG_DATA.
- REG_DATA: for a write, reg_wdata is set and reg_we pulses one cycle later. Next state is REG_DUMMY, then IDLE on the next valid. Frame length is 4 bytes.
- CH: latch channel = byte[3:0]. If channel >= N_CH, set bad_ch; the transaction runs with no strobes and reads return FILL_BYTE.
- LEN: count = byte, where 0 means 256.
  - Read: issue a prefetch read immediately (see read rule), then go to RD_DATA.
  - Write: go to WR_DATA.
- Read rule:
  - If fifo_empty[ch]=0, pulse fifo_rd[ch] for one cycle. RD_LAT cycles later, load spi_data_out with that channel's data and pulse spi_tx_valid.
  - If empty, do not strobe; load FILL_BYTE after the same latency and set unf.
- RD_DATA: on each valid, decrement count. If count was >1, issue the next read; if count was 1, go to IDLE with no read issued.
- WR_DATA: on each valid, set fifo_wdata=byte and pulse fifo_we[ch] one cycle later. If fifo_full[ch]=1 at the valid, drop the byte and set ovf. Decrement count; at 0, go to IDLE.
- Back-to-back valids are at least 8 cycles apart; all tx loads complete within RD_LAT+1 cycles of the triggering valid.
- Counter is 9 bits and never wraps below 0.

Decomposition:
- Package spi_link_pkg holds:
  - command constants CMD_REG=8'h89, CMD_FIFO_RD=8'h8A, CMD_FIFO_WR=8'h8B, CMD_STATUS=8'h8C;
  - state enum state_t;
  - status-bit index constants.
- One sub-module, spi_link_rd_pipe: an RD_LAT-deep delay line that turns a read-request event plus source select (reg/fifo/fill/status) into the tx load.

Test Plan:
- Reg write: frame 89,A4,02,00 -> reg_we pulses once with reg_addr=0x24, reg_wdata=0x02; busy returns low after the 4th byte.
- Reg read: frame 89,24,00,00 with reg_rdata=0x5A -> one spi_tx_valid with 0x5A, RD_LAT+1 cycles after the 2nd valid; reg_we never pulses.
- Burst write: 8B,01,04,FE,BA,FE,BA with ch1 not full -> fifo_we[1] pulses 4 times with data FE,BA,FE,BA; fifo_we[0] stays 0.
- Burst read with underflow: 8A,00,03 with 2 bytes in ch0 -> fifo_rd[0] pulses twice; tx loads data0, data1, 0x00; a following 8C returns 0x01 and a second 8C returns 0x00.
- Errors: 8B,00,02 with ch0 full -> no fifo_we, ovf set. 8A,05 with N_CH=2 -> no strobes, FILL returned, bad_ch set (status 0x04 if alone).
- Abort: raise spi_cs_n after the LEN byte of 8A,00,10 -> state IDLE, no further fifo_rd; the next 89 frame executes normally. Assert rst mid-burst -> all outputs 0 immediately.
